// File: rtl/cpu_run_controller.sv
// Run sequencer for a pipelined core: holds the core in reset, releases it,
// counts RUN cycles and stops on a branch-to-self halt or a cycle budget.
module cpu_run_controller #(
    parameter int PC_W         = 64,
    parameter int CNT_W        = 32,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 1400,
    parameter int HALT_STABLE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_reset,
    output logic             cpu_run,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int STB_W = $clog2(HALT_STABLE + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_HALT = STB_W'(HALT_STABLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    if (RESET_CYCLES < 1) begin : g_chk_rst
        $error("cpu_run_controller: RESET_CYCLES must be >= 1");
    end
    if (HALT_STABLE < 1) begin : g_chk_halt
        $error("cpu_run_controller: HALT_STABLE must be >= 1");
    end
    if (MAX_CYCLES < 2) begin : g_chk_max_lo
        $error("cpu_run_controller: MAX_CYCLES must be >= 2");
    end
    // The cycle counter must hold MAX_CYCLES so it can never wrap.
    if ((longint'(MAX_CYCLES) >> CNT_W) != 0) begin : g_chk_max_hi
        $error("cpu_run_controller: MAX_CYCLES must be < 2**CNT_W");
    end

    typedef enum logic [1:0] {
        IDLE,
        RESET_HOLD,
        RUN,
        DONE
    } state_e;

    state_e            state_q,      state_d;
    logic [RST_W-1:0]  rst_cnt_q,    rst_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q,  cycle_cnt_d;
    logic [STB_W-1:0]  stable_cnt_q, stable_cnt_d;
    logic [PC_W-1:0]   pc_prev_q,    pc_prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic              halted_q,     halted_d;
    logic              timed_out_q,  timed_out_d;

    logic              pc_match;
    logic [STB_W-1:0]  stable_next;

    // The first RUN edge only primes pc_prev; any mismatch restarts the streak.
    assign pc_match    = prev_valid_q && (pc == pc_prev_q);
    assign stable_next = pc_match ? (stable_cnt_q + STB_W'(1)) : '0;

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        stable_cnt_d = stable_cnt_q;
        pc_prev_d    = pc_prev_q;
        prev_valid_d = prev_valid_q;
        halted_d     = halted_q;
        timed_out_d  = timed_out_q;

        if (abort) begin
            state_d      = IDLE;
            rst_cnt_d    = '0;
            cycle_cnt_d  = '0;
            stable_cnt_d = '0;
            pc_prev_d    = '0;
            prev_valid_d = 1'b0;
            halted_d     = 1'b0;
            timed_out_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d      = RESET_HOLD;
                        rst_cnt_d    = '0;
                        cycle_cnt_d  = '0;
                        stable_cnt_d = '0;
                        prev_valid_d = 1'b0;
                        halted_d     = 1'b0;
                        timed_out_d  = 1'b0;
                    end
                end
                RESET_HOLD: begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                    if (rst_cnt_q == RST_LAST) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    cycle_cnt_d  = cycle_cnt_q + CNT_W'(1);
                    pc_prev_d    = pc;
                    prev_valid_d = 1'b1;
                    stable_cnt_d = stable_next;
                    // Halt is tested first so it wins a tie with the budget.
                    if (stable_next == STB_HALT) begin
                        state_d  = DONE;
                        halted_d = 1'b1;
                    end else if (cycle_cnt_q == CNT_LAST) begin
                        state_d     = DONE;
                        timed_out_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rst_cnt_q    <= '0;
            cycle_cnt_q  <= '0;
            stable_cnt_q <= '0;
            pc_prev_q    <= '0;
            prev_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            pc_prev_q    <= pc_prev_d;
            prev_valid_q <= prev_valid_d;
            halted_q     <= halted_d;
            timed_out_q  <= timed_out_d;
        end
    end

    assign cpu_reset   = (state_q == IDLE) || (state_q == RESET_HOLD);
    assign cpu_run     = (state_q == RUN);
    assign busy        = (state_q == RESET_HOLD) || (state_q == RUN);
    assign done        = (state_q == DONE);
    assign halted      = halted_q;
    assign timed_out   = timed_out_q;
    assign cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench: the driver pushes the expected end of each run, the monitor
// pops and compares when the DUT reports done or falls back to idle.
module tb_cpu_run_controller;

    localparam int PC_W         = 64;
    localparam int CNT_W        = 32;
    localparam int RESET_CYCLES = 2;
    localparam int MAX_CYCLES   = 20;
    localparam int HALT_STABLE  = 4;
    localparam int SEQ_N        = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [PC_W-1:0]  pc = '0;
    logic             cpu_reset, cpu_run, busy, done, halted, timed_out;
    logic [CNT_W-1:0] cycle_count;

    always #5 clk = ~clk;

    cpu_run_controller #(
        .PC_W(PC_W), .CNT_W(CNT_W), .RESET_CYCLES(RESET_CYCLES),
        .MAX_CYCLES(MAX_CYCLES), .HALT_STABLE(HALT_STABLE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pc(pc),
        .cpu_reset(cpu_reset), .cpu_run(cpu_run), .busy(busy), .done(done),
        .halted(halted), .timed_out(timed_out), .cycle_count(cycle_count)
    );

    typedef struct {
        bit is_abort;
        bit halted;
        bit timed_out;
        int cnt;
    } exp_t;

    exp_t            exp_q[$];
    logic [PC_W-1:0] seq [1:SEQ_N];
    int              checks = 0;
    int              errors = 0;
    bit              mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the run ends at the first RUN cycle whose PC equals each of
    // the previous HALT_STABLE PCs, else after MAX_CYCLES; abort beats both.
    function automatic exp_t model(input int abort_at);
        exp_t e;
        bit   all_eq;
        e = '{is_abort: 1'b0, halted: 1'b0, timed_out: 1'b0, cnt: 0};
        for (int k = 1; k <= MAX_CYCLES; k++) begin
            if (k == abort_at) begin
                e.is_abort = 1'b1;
                e.cnt = k;
                return e;
            end
            all_eq = (k > HALT_STABLE);
            if (all_eq)
                for (int j = k - HALT_STABLE; j < k; j++)
                    if (seq[j] != seq[k]) all_eq = 1'b0;
            if (all_eq) begin
                e.halted = 1'b1;
                e.cnt = k;
                return e;
            end
            if (k == MAX_CYCLES) begin
                e.timed_out = 1'b1;
                e.cnt = k;
            end
        end
        return e;
    endfunction

    // Monitor
    initial begin
        bit   prev_busy = 1'b0, prev_done = 1'b0, prev_run = 1'b0, prev_hold = 1'b0;
        int   rst_w = 0, run_obs = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (busy && cpu_reset) begin
                    if (!prev_hold) begin
                        rst_w = 0;
                        run_obs = 0;
                        chk("hold_cleared", {cycle_count, halted, timed_out, done}, '0);
                    end
                    rst_w++;
                end
                if (cpu_run) begin
                    if (!prev_run) chk("reset_width", rst_w, RESET_CYCLES);
                    run_obs++;
                    chk("run_outputs", {cpu_reset, busy, done}, 3'b010);
                end
                if (done && !prev_done) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: got done expected none at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_abort) begin
                            errors++;
                            $display("FAIL done_vs_abort: got done expected abort at %0t", $time);
                        end else begin
                            chk("done_count", cycle_count, e.cnt);
                            chk("done_halted", halted, e.halted);
                            chk("done_timed_out", timed_out, e.timed_out);
                            chk("done_run_cycles", run_obs, e.cnt);
                            chk("done_outputs", {cpu_run, cpu_reset, busy}, 3'b000);
                        end
                    end
                end
                if (!busy && !done && prev_busy) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_idle: got idle expected none at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (!e.is_abort) begin
                            errors++;
                            $display("FAIL idle_vs_done: got idle expected done cnt %0d at %0t",
                                     e.cnt, $time);
                        end else begin
                            chk("abort_count", cycle_count, 0);
                            chk("abort_run_cycles", run_obs, e.cnt);
                            chk("abort_outputs", {cpu_reset, cpu_run, halted, timed_out}, 4'b1000);
                        end
                    end
                end
            end
            prev_busy = busy;
            prev_done = done;
            prev_run  = cpu_run;
            prev_hold = busy && cpu_reset;
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called just after a rising edge; seq[k] is presented during RUN cycle k.
    task automatic run_seq(input int abort_at, input bit poke);
        exp_t e;
        e = model(abort_at);
        exp_q.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (RESET_CYCLES) @(posedge clk);
        #1;
        pc = seq[1];
        abort = (abort_at == 1);
        for (int k = 2; k <= e.cnt; k++) begin
            @(posedge clk); #1;
            pc = seq[k];
            abort = (abort_at == k);
            start = poke && (k == 3);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [PC_W-1:0] cur;
        int              ab;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_outputs", {cpu_reset, cpu_run, busy, done, halted, timed_out}, 6'b100000);
            chk("idle_count", cycle_count, 0);
        end
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Halt after advancing PC, with a start pulse mid-run that must be ignored
        for (int k = 1; k <= SEQ_N; k++) seq[k] = (k <= 7) ? PC_W'(4 * (k - 1)) : PC_W'(24);
        run_seq(0, 1'b1);

        // A one-cycle blip at stable count 3 restarts detection
        seq[11] = PC_W'(100);
        run_seq(0, 1'b0);

        // Timeout with a steadily advancing PC, then restart straight from DONE
        for (int k = 1; k <= SEQ_N; k++) seq[k] = PC_W'(4 * k);
        run_seq(0, 1'b0);

        // Halt and budget land on the same edge
        for (int k = 1; k <= SEQ_N; k++) seq[k] = (k < 16) ? PC_W'(4 * k) : PC_W'(64);
        run_seq(0, 1'b0);

        // Abort in RUN cycle 7
        for (int k = 1; k <= SEQ_N; k++) seq[k] = PC_W'(4 * k);
        run_seq(7, 1'b0);
        for (int k = 1; k <= SEQ_N; k++) seq[k] = PC_W'(8 * k);
        run_seq(0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            cur = PC_W'($urandom_range(0, 3) * 4);
            for (int k = 1; k <= SEQ_N; k++) begin
                if ($urandom_range(0, 3) == 0) cur = PC_W'($urandom_range(0, 3) * 4);
                seq[k] = cur;
            end
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAX_CYCLES)) : 0;
            run_seq(ab, 1'(($urandom_range(0, 1))));
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
